simple_op_sched: RTL
====================

SIMPLE_OP_SCHED -- requirements
Module: simple_op_sched

Interface
REQ-001 Parameter WIDTH1, default 3: lane-1 data width.
REQ-002 Parameter WIDTH2, default 6: lane-2 data width; WIDTH2 SHALL be >= WIDTH1.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in1_data  input  WIDTH1  requester-1 payload.
REQ-006 in1_valid  input  1  requester-1 request.
REQ-007 in1_ready  output  1  requester-1 accepted this cycle.
REQ-008 in2_data  input  WIDTH2  requester-2 payload.
REQ-009 in2_valid  input  1  requester-2 request.
REQ-010 in2_ready  output  1  requester-2 accepted this cycle.
REQ-011 out_data  output  WIDTH2  shared-lane payload; lane-1 data zero-extended.
REQ-012 out_src  output  1  0 = from requester 1, 1 = from requester 2.
REQ-013 out_valid  output  1  out_data/out_src hold a word.
REQ-014 out_ready  input  1  consumer takes word when out_valid && out_ready.
REQ-015 grant_cnt1, grant_cnt2  output  8 each  per-requester grant counters.

Function
REQ-016 Two states: IDLE (out_valid=0), HOLD (out_valid=1, one-word output register full).
REQ-017 Accept slot open = IDLE, or HOLD with out_ready=1 (same-cycle drain and refill).
REQ-018 Grant only when slot open; at most one in*_ready high per cycle; in*_ready combinational from valids, slot, and priority pointer.
REQ-019 One requester valid: it is granted.
REQ-020 Both valid: round-robin; requester not granted last wins; pointer updates only on an actual grant.
REQ-021 On grant: out_data, out_src, out_valid=1 registered next edge; request-to-out_valid latency exactly 1 cycle.
REQ-022 Lane-1 word: out_data[WIDTH1-1:0]=in1_data, upper WIDTH2-WIDTH1 bits 0.
REQ-023 HOLD with out_ready=0: out_data, out_src, out_valid stable; both in*_ready low.
REQ-024 HOLD, out_ready=1, no request: next state IDLE, out_valid=0; out_data holds last value.
REQ-025 Sustained traffic with out_ready=1: one word per cycle, no bubble.
REQ-026 Requester deasserting valid before grant: no word emitted for it, pointer unchanged.

Reset
REQ-027 reset=1 at an edge: state IDLE, out_valid=0, out_data=0, out_src=0, pointer favours requester 1, counters 0.
REQ-028 Reset overrides any same-cycle grant; in*_ready SHALL be 0 while reset=1; a held word is discarded.

Configuration
REQ-029 Macro SIMPLE_OP_SCHED_GRANT_COUNT_EN defined: grant_cnt1/grant_cnt2 increment by 1 per grant to that requester, saturating at 255, cleared by reset.
REQ-030 Macro undefined: grant_cnt1 = grant_cnt2 = 0 constantly, no counter registers; all other behaviour identical.

Structure
REQ-031 Shared package simple_op_sched_pkg holds the state encoding (IDLE=0, HOLD=1), default WIDTH1/WIDTH2, and counter width 8.
REQ-032 Round-robin decision in sub-module rr_arbiter2 (two requests, enable, two one-hot grants, internal pointer); top instantiates it once.

Verification
REQ-033 Reset, then in1_valid=1, in1_data=3'b101, out_ready=1 -> in1_ready=1 same cycle; next cycle out_valid=1, out_data=6'b000101, out_src=0.
REQ-034 Both valid continuously, out_ready=1, from reset -> grants alternate 1,2,1,2; out_src sequence 0,1,0,1, one word per cycle.
REQ-035 Word held, out_ready=0 for 5 cycles, in2_valid=1 -> out_data stable, in2_ready=0 all 5 cycles; out_ready=1 -> in2 granted same cycle, its word valid next cycle.
REQ-036 reset asserted in HOLD with in1_valid=1 -> in1_ready=0 that cycle; after edge out_valid=0, out_data=0; first post-reset contest grants requester 1.
REQ-037 Macro defined, 300 grants to requester 2 -> grant_cnt2=255, grant_cnt1 unchanged; macro undefined, same stimulus -> both counters 0.

Source files
------------

// File: rtl/simple_op_sched_pkg.sv
// Shared definitions for simple_op_sched: state encoding, default lane
// widths and grant-counter width.
package simple_op_sched_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  localparam int DEF_WIDTH1 = 3;
  localparam int DEF_WIDTH2 = 6;
  localparam int CNT_W      = 8;

endpackage

// File: rtl/simple_op_sched_rr_arbiter2.sv
// rr_arbiter2: two-requester round-robin arbiter. Grants are one-hot and
// combinational; the priority pointer only moves when a grant is issued.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  // prio_q = 0 favours requester 0, 1 favours requester 1
  logic prio_q, prio_d;

  // grant selection and pointer advance
  always_comb begin
    gnt_o  = 2'b00;
    prio_d = prio_q;
    if (en_i) begin
      if (req_i[0] && (!req_i[1] || !prio_q)) gnt_o[0] = 1'b1;
      else if (req_i[1])                      gnt_o[1] = 1'b1;
    end
    // the requester just served loses the next contest
    if (gnt_o[0])      prio_d = 1'b1;
    else if (gnt_o[1]) prio_d = 1'b0;
  end

  // priority pointer register
  always_ff @(posedge clk) begin
    if (reset) prio_q <= 1'b0;
    else       prio_q <= prio_d;
  end

endmodule

// File: rtl/simple_op_sched.sv
// simple_op_sched: two requesters share one output lane through a one-word
// output register; round-robin when both request.
// Optional build macro SIMPLE_OP_SCHED_GRANT_COUNT_EN adds saturating
// per-requester grant counters; without it grant_cnt1/2 are tied to zero.
module simple_op_sched
  import simple_op_sched_pkg::*;
#(
  parameter int WIDTH1 = DEF_WIDTH1,
  parameter int WIDTH2 = DEF_WIDTH2   // must be >= WIDTH1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH1-1:0] in1_data,
  input  logic              in1_valid,
  output logic              in1_ready,
  input  logic [WIDTH2-1:0] in2_data,
  input  logic              in2_valid,
  output logic              in2_ready,
  output logic [WIDTH2-1:0] out_data,
  output logic              out_src,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  grant_cnt1,
  output logic [CNT_W-1:0]  grant_cnt2
);

  state_e            state_q, state_d;
  logic [WIDTH2-1:0] data_q, data_d;
  logic              src_q, src_d;
  logic              slot_open;
  logic [1:0]        gnt;

  // slot is open when empty, or full but draining this very cycle;
  // reset masks the arbiter so nothing is granted while it is held
  assign slot_open = (state_q == ST_IDLE) || out_ready;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .reset (reset),
    .en_i  (slot_open && !reset),
    .req_i ({in2_valid, in1_valid}),
    .gnt_o (gnt)
  );

  assign in1_ready = gnt[0];
  assign in2_ready = gnt[1];

  // next-state: load on grant, drop to IDLE when drained with no refill
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    src_d   = src_q;
    if (gnt[0]) begin
      state_d = ST_HOLD;
      data_d  = WIDTH2'(in1_data);
      src_d   = 1'b0;
    end else if (gnt[1]) begin
      state_d = ST_HOLD;
      data_d  = in2_data;
      src_d   = 1'b1;
    end else if (state_q == ST_HOLD && out_ready) begin
      // data/src intentionally keep the last word
      state_d = ST_IDLE;
    end
  end

  // output register / state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      src_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      src_q   <= src_d;
    end
  end

  assign out_valid = (state_q == ST_HOLD);
  assign out_data  = data_q;
  assign out_src   = src_q;

`ifdef SIMPLE_OP_SCHED_GRANT_COUNT_EN
  logic [CNT_W-1:0] cnt1_q, cnt1_d, cnt2_q, cnt2_d;

  // saturating grant counters
  always_comb begin
    cnt1_d = cnt1_q;
    cnt2_d = cnt2_q;
    if (gnt[0] && (cnt1_q != {CNT_W{1'b1}})) cnt1_d = cnt1_q + 1'b1;
    if (gnt[1] && (cnt2_q != {CNT_W{1'b1}})) cnt2_d = cnt2_q + 1'b1;
  end

  // counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt1_q <= '0;
      cnt2_q <= '0;
    end else begin
      cnt1_q <= cnt1_d;
      cnt2_q <= cnt2_d;
    end
  end

  assign grant_cnt1 = cnt1_q;
  assign grant_cnt2 = cnt2_q;
`else
  assign grant_cnt1 = '0;
  assign grant_cnt2 = '0;
`endif

endmodule
